alu_cmd_ctrl: RTL and testbench
===============================

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of operands, result and byte bus.
REQ-002 SHALL have parameter CMD_ALU_OP, default 8'hCC: command with operands (frame CMD, A, B, FUN).
REQ-003 SHALL have parameter CMD_ALU_NOP, default 8'hDD: command reusing stored operands (frame CMD, FUN).
REQ-004 SHALL have a single clock and an asynchronous, active-high reset: CLK in 1, rising-edge clock; RST in 1, asynchronous active-high reset.
REQ-005 RX_P_DATA  in  DATA_WIDTH  received byte.
REQ-006 RX_D_VLD  in  1  one-cycle strobe qualifying RX_P_DATA.
REQ-007 ALU_OUT  in  DATA_WIDTH  registered ALU result.
REQ-008 OUT_VALID  in  1  ALU result-valid flag.
REQ-009 TX_BUSY  in  1  transmitter busy; new data not accepted while high.
REQ-010 A  out  DATA_WIDTH  operand A to ALU.
REQ-011 B  out  DATA_WIDTH  operand B to ALU.
REQ-012 ALU_FUN  out  4  ALU function code.
REQ-013 ALU_EN  out  1  ALU enable.
REQ-014 TX_P_DATA  out  DATA_WIDTH  result byte to transmitter.
REQ-015 TX_D_VLD  out  1  one-cycle strobe qualifying TX_P_DATA.
REQ-016 BUSY  out  1  high in every state except IDLE, GET_A, GET_B, GET_FUN.
REQ-017 ERR  out  1  one-cycle pulse on ALU result timeout.

Function
REQ-018 SHALL implement FSM states IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND; all outputs registered or decoded from state only.
REQ-019 IDLE: RX_D_VLD with CMD_ALU_OP -> GET_A; with CMD_ALU_NOP -> GET_FUN; any other byte ignored, stay IDLE.
REQ-020 GET_A: on RX_D_VLD load A register, -> GET_B; GET_B: on RX_D_VLD load B register, -> GET_FUN.
REQ-021 GET_FUN: on RX_D_VLD load ALU_FUN from RX_P_DATA[3:0] (upper bits ignored), -> ALU_RUN.
REQ-022 ALU_RUN lasts exactly one cycle with ALU_EN=1; A, B, ALU_FUN stable; -> WAIT_RES. ALU_EN SHALL be 0 in every other state.
REQ-023 WAIT_RES: on OUT_VALID=1 capture ALU_OUT into result register, -> SEND; 2-bit counter cleared on entry.
REQ-024 WAIT_RES: if OUT_VALID not seen within 4 cycles, -> IDLE, ERR=1 for one cycle, no transmission.
REQ-025 SEND: when TX_BUSY=0, TX_D_VLD=1 for exactly one cycle with TX_P_DATA=captured result, -> IDLE; while TX_BUSY=1 wait, TX_D_VLD=0, TX_P_DATA held.
REQ-026 Latency: FUN strobe in cycle N -> ALU_EN in N+1 -> OUT_VALID expected N+2 -> TX_D_VLD in N+3 (TX_BUSY=0).
REQ-027 RX_D_VLD in ALU_RUN, WAIT_RES, SEND SHALL be discarded (no buffering, no state effect).
REQ-028 A and B SHALL hold their last loaded values across frames; CMD_ALU_NOP uses them unchanged.
REQ-029 TX_P_DATA SHALL hold last transmitted value after SEND until next capture.

Reset
REQ-030 RST=1 SHALL immediately force IDLE; A=0, B=0, ALU_FUN=0, ALU_EN=0, TX_P_DATA=0, TX_D_VLD=0, BUSY=0, ERR=0, counter=0.
REQ-031 Reset mid-frame SHALL discard partial frame; first RX_D_VLD after release is treated as a command byte.

Verification
REQ-032 Frame CC,05,03,00 with ALU model returning 08 at N+2 -> ALU_EN one cycle at N+1 with A=05,B=03,ALU_FUN=0; TX_D_VLD one cycle at N+3, TX_P_DATA=08.
REQ-033 After REQ-032, frame DD,01, model returns 02 -> ALU_EN with A=05,B=03,ALU_FUN=1; TX_P_DATA=02.
REQ-034 Frame CC,0A,02,F2 with TX_BUSY=1 for 10 cycles after capture -> ALU_FUN=2; TX_D_VLD=0 while busy, single pulse the cycle TX_BUSY=0, BUSY high throughout.
REQ-035 Frame CC,01,01,00 with OUT_VALID held 0 -> ERR single pulse after 4 WAIT_RES cycles, no TX_D_VLD, BUSY=0 next cycle.
REQ-036 Byte 7E in IDLE, then extra bytes during WAIT_RES -> no state change, no ALU_EN / TX_D_VLD from them.
REQ-037 RST pulsed after CC,09 -> all outputs reset per REQ-030; following CC,04,04,00 completes normally.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command controller for an external ALU: collects operand/function
// frames, fires the ALU for one cycle, waits (bounded) for the result and sends it back.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  BUSY,
    output logic                  ERR
);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] wait_cnt;
    logic       load_a, load_b, load_fun, capture;
    logic       cnt_clr, cnt_inc;
    logic       tx_pulse_nxt, err_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_fun     = 1'b0;
        capture      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        tx_pulse_nxt = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OP)       state_nxt = GET_A;
                    else if (RX_P_DATA == CMD_ALU_NOP) state_nxt = GET_FUN;
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    load_a    = 1'b1;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    load_b    = 1'b1;
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    load_fun  = 1'b1;
                    state_nxt = ALU_RUN;
                end
            end
            ALU_RUN: begin
                cnt_clr   = 1'b1;
                state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (OUT_VALID) begin
                    capture      = 1'b1;
                    tx_pulse_nxt = !TX_BUSY;
                    state_nxt    = SEND;
                end else if (wait_cnt == 2'd3) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SEND: begin
                // leave once the pulse is on the wire; otherwise arm it when TX is free
                if (TX_D_VLD)      state_nxt    = IDLE;
                else if (!TX_BUSY) tx_pulse_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            ERR       <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (load_a)   A         <= RX_P_DATA;
            if (load_b)   B         <= RX_P_DATA;
            if (load_fun) ALU_FUN   <= RX_P_DATA[3:0];
            if (capture)  TX_P_DATA <= ALU_OUT;
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 2'd1;
            TX_D_VLD <= tx_pulse_nxt;
            ERR      <= err_nxt;
        end
    end

    assign ALU_EN = (state == ALU_RUN);
    assign BUSY   = (state == ALU_RUN) || (state == WAIT_RES) || (state == SEND);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: frame table plus hand sequences for
// TX back-pressure, result timeout, stray bytes and mid-frame reset.
module tb_alu_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] ALU_OUT = '0;
    logic       OUT_VALID = 1'b0;
    logic       TX_BUSY = 1'b0;
    logic [7:0] A, B, TX_P_DATA;
    logic [3:0] ALU_FUN;
    logic       ALU_EN, TX_D_VLD, BUSY, ERR;

    alu_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .TX_BUSY(TX_BUSY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // ALU stand-in: answers alu_lat cycles after ALU_EN unless alu_dead
    int         alu_lat  = 1;
    logic       alu_dead = 1'b0;
    int         pend = 0;
    logic [7:0] hold = '0;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return 8'(a * b);
            4'd3:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge CLK) begin
        OUT_VALID <= 1'b0;
        if (ALU_EN && !alu_dead) begin
            if (alu_lat == 1) begin
                OUT_VALID <= 1'b1;
                ALU_OUT   <= alu_f(A, B, ALU_FUN);
            end else begin
                pend <= alu_lat - 1;
                hold <= alu_f(A, B, ALU_FUN);
            end
        end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                OUT_VALID <= 1'b1;
                ALU_OUT   <= hold;
            end
        end
    end

    // event monitor, sampled mid-cycle
    int cyc = 0;
    int rx_cyc = 0, en_cnt = 0, en_cyc = 0, tx_cnt = 0, tx_cyc = 0, err_cnt = 0, err_cyc = 0;
    logic [7:0] en_a = '0, en_b = '0, tx_data = '0;
    logic [3:0] en_fun = '0;
    logic       err_busy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RX_D_VLD) rx_cyc = cyc;
        if (ALU_EN) begin
            en_cnt++; en_cyc = cyc; en_a = A; en_b = B; en_fun = ALU_FUN;
        end
        if (TX_D_VLD) begin
            tx_cnt++; tx_cyc = cyc; tx_data = TX_P_DATA;
        end
        if (ERR) begin
            err_cnt++; err_cyc = cyc; err_busy = BUSY;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    typedef struct {
        logic [7:0] bytes [4];
        int         n;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [3:0] exp_fun;
        logic [7:0] exp_tx;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input int n, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] f, input logic [7:0] tx);
        vec_t v;
        v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2; v.bytes[3] = b3;
        v.n = n; v.exp_a = a; v.exp_b = b; v.exp_fun = f; v.exp_tx = tx;
        return v;
    endfunction

    // full frame with TX idle: ALU_EN at N+1, TX_D_VLD at N+3
    task automatic run_vec(input vec_t v, input string tag);
        int e0, t0, r0, fc;
        e0 = en_cnt; t0 = tx_cnt; r0 = err_cnt;
        for (int i = 0; i < v.n; i++) send_byte(v.bytes[i]);
        fc = rx_cyc;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk({tag, " en_count"}, en_cnt - e0, 1);
        chk({tag, " en_a"}, en_a, v.exp_a);
        chk({tag, " en_b"}, en_b, v.exp_b);
        chk({tag, " en_fun"}, en_fun, v.exp_fun);
        chk({tag, " en_latency"}, en_cyc - fc, 1);
        chk({tag, " tx_count"}, tx_cnt - t0, 1);
        chk({tag, " tx_data"}, tx_data, v.exp_tx);
        chk({tag, " tx_latency"}, tx_cyc - fc, 3);
        chk({tag, " err_count"}, err_cnt - r0, 0);
        chk({tag, " tx_hold"}, TX_P_DATA, v.exp_tx);
        chk({tag, " busy_after"}, BUSY, 0);
    endtask

    vec_t vecs [5];

    initial begin
        int e0, t0, r0, fc, viol;

        vecs[0] = mk(8'hCC, 8'h05, 8'h03, 8'h00, 4, 8'h05, 8'h03, 4'd0, 8'h08);
        vecs[1] = mk(8'hDD, 8'h01, 8'h00, 8'h00, 2, 8'h05, 8'h03, 4'd1, 8'h02);
        vecs[2] = mk(8'hCC, 8'h0F, 8'hF0, 8'h73, 4, 8'h0F, 8'hF0, 4'd3, 8'hFF);
        vecs[3] = mk(8'hDD, 8'h00, 8'h00, 8'h00, 2, 8'h0F, 8'hF0, 4'd0, 8'hFF);
        vecs[4] = mk(8'hCC, 8'hFF, 8'h02, 8'h00, 4, 8'hFF, 8'h02, 4'd0, 8'h01);

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst A", A, 0);
        chk("rst B", B, 0);
        chk("rst fun", ALU_FUN, 0);
        chk("rst en", ALU_EN, 0);
        chk("rst txdata", TX_P_DATA, 0);
        chk("rst txvld", TX_D_VLD, 0);
        chk("rst busy", BUSY, 0);
        chk("rst err", ERR, 0);
        @(posedge CLK); #3; RST = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // TX back-pressure: held 10+ cycles past capture
        TX_BUSY = 1'b1;
        e0 = en_cnt; t0 = tx_cnt;
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h02); send_byte(8'hF2);
        fc = rx_cyc;
        viol = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            if (TX_D_VLD || !BUSY) viol++;
        end
        chk("busy hold_violations", viol, 0);
        chk("busy fun", ALU_FUN, 4'd2);
        @(posedge CLK); #1; TX_BUSY = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("busy en_count", en_cnt - e0, 1);
        chk("busy tx_count", tx_cnt - t0, 1);
        chk("busy tx_data", tx_data, 8'h14);
        chk("busy tx_cycle", tx_cyc - fc, 13);
        chk("busy idle_after", BUSY, 0);

        // result timeout
        alu_dead = 1'b1;
        t0 = tx_cnt; r0 = err_cnt;
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        fc = rx_cyc;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        chk("tmo err_count", err_cnt - r0, 1);
        chk("tmo err_cycle", err_cyc - fc, 6);
        chk("tmo busy_at_err", err_busy, 0);
        chk("tmo tx_count", tx_cnt - t0, 0);
        chk("tmo tx_hold", TX_P_DATA, 8'h14);
        alu_dead = 1'b0;

        // stray byte in IDLE, then bytes during ALU_RUN/WAIT_RES
        alu_lat = 3;
        e0 = en_cnt; t0 = tx_cnt;
        send_byte(8'h7E);
        repeat (2) @(negedge CLK);
        chk("junk idle_busy", BUSY, 0);
        chk("junk idle_en", en_cnt - e0, 0);
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        fc = rx_cyc;
        RX_P_DATA = 8'hDD; RX_D_VLD = 1'b1;
        repeat (3) @(posedge CLK);
        #1; RX_D_VLD = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("junk en_count", en_cnt - e0, 1);
        chk("junk tx_count", tx_cnt - t0, 1);
        chk("junk tx_data", tx_data, 8'h03);
        chk("junk tx_cycle", tx_cyc - fc, 5);
        chk("junk idle_after", BUSY, 0);
        alu_lat = 1;
        run_vec(mk(8'hDD, 8'h02, 8'h00, 8'h00, 2, 8'h01, 8'h02, 4'd2, 8'h02), "junk_follow");

        // reset mid-frame
        send_byte(8'hCC); send_byte(8'h09);
        @(posedge CLK); #3; RST = 1'b1;
        #1;
        chk("mid rst A", A, 0);
        chk("mid rst B", B, 0);
        chk("mid rst fun", ALU_FUN, 0);
        chk("mid rst en", ALU_EN, 0);
        chk("mid rst txdata", TX_P_DATA, 0);
        chk("mid rst txvld", TX_D_VLD, 0);
        chk("mid rst busy", BUSY, 0);
        chk("mid rst err", ERR, 0);
        @(posedge CLK); #3; RST = 1'b0;
        run_vec(mk(8'hCC, 8'h04, 8'h04, 8'h00, 4, 8'h04, 8'h04, 4'd0, 8'h08), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
